// File: rtl/msg_schedule_pkg.sv
// Shared types and constants for the SHA message-schedule generator.
//   mode_e       : hash family selected at block start
//   state_e      : schedule controller states
//   Rounds*      : number of schedule words issued per block
//   WindowDepth  : sliding window of the most recent 16 schedule words
package msg_schedule_pkg;

    typedef enum logic [1:0] {
        ModeSha1   = 2'd0,
        ModeSha256 = 2'd1,
        ModeSha512 = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExtend,
        StDrain
    } state_e;

    localparam int unsigned RoundsSha256 = 64;
    localparam int unsigned RoundsLong   = 80;
    localparam int unsigned WindowDepth  = 16;
    localparam int unsigned IdxWidth     = 7;

    // Index of the final schedule word for the given mode.
    function automatic logic [IdxWidth-1:0] last_idx(input mode_e m);
        return (m == ModeSha256) ? IdxWidth'(RoundsSha256 - 1) : IdxWidth'(RoundsLong - 1);
    endfunction

endpackage

// File: rtl/msg_sigma.sv
// Combinational small-sigma functions of the SHA-2 message schedule.
//   mode : selects the 64-bit (SHA-512) or 32-bit (SHA-256) variant
//   x0   : word fed to sigma0 (W[t-15])
//   x1   : word fed to sigma1 (W[t-2])
//   s0   : sigma0(x0); upper half is zero in 32-bit modes
//   s1   : sigma1(x1); upper half is zero in 32-bit modes
module msg_sigma
    import msg_schedule_pkg::*;
#(
    parameter bit SUPPORT_512 = 1'b1
) (
    input  mode_e       mode,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    output logic [63:0] s0,
    output logic [63:0] s1
);

    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] s0_32;
    logic [31:0] s1_32;
    logic [63:0] s0_64;
    logic [63:0] s1_64;
    logic        wide;

    assign a32 = x0[31:0];
    assign b32 = x1[31:0];

    assign s0_32 = {a32[6:0], a32[31:7]} ^ {a32[17:0], a32[31:18]} ^ (a32 >> 3);
    assign s1_32 = {b32[16:0], b32[31:17]} ^ {b32[18:0], b32[31:19]} ^ (b32 >> 10);

    assign s0_64 = {x0[0], x0[63:1]} ^ {x0[7:0], x0[63:8]} ^ (x0 >> 7);
    assign s1_64 = {x1[18:0], x1[63:19]} ^ {x1[60:0], x1[63:61]} ^ (x1 >> 6);

    assign wide = SUPPORT_512 && (mode == ModeSha512);

    assign s0 = wide ? s0_64 : {32'h0, s0_32};
    assign s1 = wide ? s1_64 : {32'h0, s1_32};

endmodule

// File: rtl/msg_schedule.sv
// SHA-1 / SHA-256 / SHA-512 message-schedule generator.
// Accepts the 16 block words, then streams W0..W(rounds-1) through a single
// output register with a valid/ready handshake.
//   clk, rst_ext           : clock, synchronous active-high reset
//   start, mode            : begin a block in the given mode (3 is illegal)
//   in_valid/in_word/in_ready : block-word input, W0 first
//   w_valid/w_word/w_idx/w_ready : schedule-word output stream
//   busy                   : block in progress
//   done                   : one-cycle pulse after the last word is consumed
//   err                    : one-cycle pulse after an illegal start
module msg_schedule
    import msg_schedule_pkg::*;
#(
    parameter bit SUPPORT_512 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_ext,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    input  logic [63:0] in_word,
    output logic        in_ready,
    output logic        w_valid,
    output logic [63:0] w_word,
    output logic [6:0]  w_idx,
    input  logic        w_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [63:0]         win_q [WindowDepth];
    logic [63:0]         win_d [WindowDepth];
    logic                w_valid_q, w_valid_d;
    logic [63:0]         w_word_q, w_word_d;
    logic [6:0]          w_idx_q, w_idx_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic        advance;
    logic        mode_legal;
    logic        wide;
    logic        in_xfer;
    logic [63:0] load_word;
    logic [63:0] sig0, sig1;
    logic [31:0] sha1_x;
    logic [63:0] sum2;
    logic [63:0] next_word;
    logic        shift_en;
    logic [63:0] shift_word;

    // Output register may accept a new word when empty or being consumed.
    assign advance    = !w_valid_q || w_ready;
    assign mode_legal = (mode == ModeSha1) || (mode == ModeSha256)
                        || (SUPPORT_512 && (mode == ModeSha512));
    assign wide       = SUPPORT_512 && (mode_q == ModeSha512);
    assign in_xfer    = (state_q == StLoad) && in_valid && advance;
    assign load_word  = wide ? in_word : {32'h0, in_word[31:0]};

    // Window layout: win_q[15] = W[t-1] ... win_q[0] = W[t-16].
    msg_sigma #(
        .SUPPORT_512(SUPPORT_512)
    ) u_sigma (
        .mode(mode_q),
        .x0  (win_q[1]),
        .x1  (win_q[14]),
        .s0  (sig0),
        .s1  (sig1)
    );

    assign sha1_x = win_q[13][31:0] ^ win_q[8][31:0] ^ win_q[2][31:0] ^ win_q[0][31:0];
    // Window and sigma upper halves are zero in 32-bit modes, so the low half
    // of the 64-bit sum is the mod 2^32 sum.
    assign sum2   = sig1 + win_q[9] + sig0 + win_q[0];

    always_comb begin
        next_word = '0;
        if (mode_q == ModeSha1) begin
            next_word = {32'h0, sha1_x[30:0], sha1_x[31]};
        end else if (wide) begin
            next_word = sum2;
        end else begin
            next_word = {32'h0, sum2[31:0]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && mode_legal) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (in_xfer && (idx_q == IdxWidth'(WindowDepth - 1))) begin
                    state_d = StExtend;
                end
            end
            StExtend: begin
                if (advance && (idx_q == last_idx(mode_q))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_valid_q && w_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Combinational outputs.
    always_comb begin
        busy     = (state_q != StIdle);
        in_ready = (state_q == StLoad) && advance;
    end

    // Datapath next-state.
    always_comb begin
        mode_d     = mode_q;
        idx_d      = idx_q;
        w_valid_d  = w_valid_q;
        w_word_d   = w_word_q;
        w_idx_d    = w_idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        shift_en   = 1'b0;
        shift_word = '0;
        win_d      = win_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (mode_legal) begin
                        mode_d = mode_e'(mode);
                        idx_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (advance) begin
                    w_valid_d = in_valid;
                    if (in_valid) begin
                        shift_en   = 1'b1;
                        shift_word = load_word;
                    end
                end
            end
            StExtend: begin
                if (advance) begin
                    w_valid_d  = 1'b1;
                    shift_en   = 1'b1;
                    shift_word = next_word;
                end
            end
            StDrain: begin
                if (w_valid_q && w_ready) begin
                    w_valid_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase

        if (shift_en) begin
            for (int i = 0; i < int'(WindowDepth) - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[WindowDepth-1] = shift_word;
            w_word_d = shift_word;
            w_idx_d  = idx_q;
            idx_d    = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            mode_q    <= ModeSha1;
            idx_q     <= '0;
            w_valid_q <= 1'b0;
            w_word_q  <= '0;
            w_idx_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < int'(WindowDepth); i++) begin
                win_q[i] <= '0;
            end
        end else begin
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            w_valid_q <= w_valid_d;
            w_word_q  <= w_word_d;
            w_idx_q   <= w_idx_d;
            done_q    <= done_d;
            err_q     <= err_d;
            win_q     <= win_d;
        end
    end

    assign w_valid = w_valid_q;
    assign w_word  = w_word_q;
    assign w_idx   = w_idx_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule: table of block vectors plus
// hand-written sequences for illegal start, ignored start and mid-block reset.
module tb_msg_schedule;
    import msg_schedule_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ext;
    logic        start;
    logic [1:0]  mode;
    logic        in_valid;
    logic [63:0] in_word;
    logic        in_ready;
    logic        w_valid;
    logic [63:0] w_word;
    logic [6:0]  w_idx;
    logic        w_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    msg_schedule #(
        .SUPPORT_512(1'b1)
    ) dut (
        .clk     (clk),
        .rst_ext (rst_ext),
        .start   (start),
        .mode    (mode),
        .in_valid(in_valid),
        .in_word (in_word),
        .in_ready(in_ready),
        .w_valid (w_valid),
        .w_word  (w_word),
        .w_idx   (w_idx),
        .w_ready (w_ready),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [63:0] w0;
        logic [63:0] w15;
        bit          stall;
        logic [63:0] e16;
        logic [63:0] e17;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] blk [16];
    logic [63:0] exp_w [80];
    logic [63:0] got_w [80];
    logic [6:0]  got_idx [80];
    int          n_got, n_done, n_err, n_hold_bad, n_bubble, first_xfer, first_valid;
    bit          busy_end_bad;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference schedule computed directly from the standard recurrences.
    task automatic build_model(input logic [1:0] m);
        logic [31:0] a;
        for (int t = 0; t < 16; t++) begin
            exp_w[t] = (m == 2'd2) ? blk[t] : {32'h0, blk[t][31:0]};
        end
        for (int t = 16; t < 80; t++) begin
            if (m == 2'd0) begin
                a = exp_w[t-3][31:0] ^ exp_w[t-8][31:0] ^ exp_w[t-14][31:0] ^ exp_w[t-16][31:0];
                exp_w[t] = {32'h0, rotr32(a, 31)};
            end else if (m == 2'd1) begin
                a = (rotr32(exp_w[t-2][31:0], 17) ^ rotr32(exp_w[t-2][31:0], 19)
                     ^ (exp_w[t-2][31:0] >> 10))
                    + exp_w[t-7][31:0]
                    + (rotr32(exp_w[t-15][31:0], 7) ^ rotr32(exp_w[t-15][31:0], 18)
                       ^ (exp_w[t-15][31:0] >> 3))
                    + exp_w[t-16][31:0];
                exp_w[t] = {32'h0, a};
            end else begin
                exp_w[t] = (rotr64(exp_w[t-2], 19) ^ rotr64(exp_w[t-2], 61) ^ (exp_w[t-2] >> 6))
                           + exp_w[t-7]
                           + (rotr64(exp_w[t-15], 1) ^ rotr64(exp_w[t-15], 8)
                              ^ (exp_w[t-15] >> 7))
                           + exp_w[t-16];
            end
        end
    endtask

    task automatic load_blk(input logic [63:0] w0, input logic [63:0] w15);
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = w0;
        blk[15] = w15;
    endtask

    // Runs one block. Entered at posedge+1; returns at posedge+1, or at the
    // negedge after the reset when rst_at triggers (start already raised).
    task automatic run_block(input logic [1:0] m, input bit stall, input bit pre,
                             input int poke_at, input int rst_at);
        int          k = 0;
        int          cyc = 0;
        int          tail = 0;
        int          rounds;
        bit          hold = 0;
        bit          fin = 0;
        bit          poked = 0;
        logic [63:0] prev_w = '0;
        logic [6:0]  prev_i = '0;
        rounds = (m == 2'd1) ? 64 : 80;
        n_got = 0; n_done = 0; n_err = 0; n_hold_bad = 0; n_bubble = 0;
        first_xfer = -1; first_valid = -1; busy_end_bad = 0;
        for (int i = 0; i < 80; i++) begin
            got_w[i]   = 'x;
            got_idx[i] = 'x;
        end
        if (!pre) begin
            start = 1'b1;
            mode  = m;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!fin) begin
            in_valid = (k < 16) && (!stall || $urandom_range(0, 3) != 0);
            in_word  = (k < 16) ? blk[k] : 64'h0;
            w_ready  = !stall || ($urandom_range(0, 2) != 0);
            start    = 1'b0;
            if (poke_at >= 0 && !poked && n_got > 0 && int'(got_idx[n_got-1]) == poke_at) begin
                start = 1'b1;
                mode  = 2'd3;
                poked = 1;
            end
            if (rst_at >= 0 && n_got > 0 && int'(got_idx[n_got-1]) == rst_at) begin
                rst_ext  = 1'b1;
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                rst_ext = 1'b0;
                start   = 1'b1;
                mode    = 2'd1;
                @(negedge clk);
                check64("midrst_w_word", w_word, 64'h0);
                check64("midrst_ctrl", {52'h0, w_valid, w_idx, in_ready, busy, done, err}, 64'h0);
                return;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (first_xfer < 0) first_xfer = cyc;
                k++;
            end
            if (w_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (hold && (w_word !== prev_w || w_idx !== prev_i)) n_hold_bad++;
                if (w_ready && n_got < 80) begin
                    got_w[n_got]   = w_word;
                    got_idx[n_got] = w_idx;
                    n_got++;
                end
            end else if (first_valid >= 0 && n_done == 0 && n_got < rounds) begin
                n_bubble++;
            end
            hold   = w_valid && !w_ready;
            prev_w = w_word;
            prev_i = w_idx;
            if (err) n_err++;
            if (done) begin
                n_done++;
                if (busy) busy_end_bad = 1;
            end
            if (n_done > 0) tail++;
            if (tail >= 4 || cyc >= 3000) fin = 1;
            cyc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        w_ready  = 1'b0;
    endtask

    task automatic check_block(input string nm, input logic [1:0] m, input bit stall,
                               input logic [63:0] e16, input logic [63:0] e17);
        int rounds;
        int bad = -1;
        rounds = (m == 2'd1) ? 64 : 80;
        check64({nm, "_w16"}, got_w[16], e16);
        check64({nm, "_w17"}, got_w[17], e17);
        check64({nm, "_count"}, 64'(n_got), 64'(rounds));
        for (int i = 0; i < rounds; i++) begin
            if (bad < 0 && (got_w[i] !== exp_w[i] || got_idx[i] !== 7'(i))) bad = i;
        end
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s_seq: word %0d got idx %0d data %h, expected idx %0d data %h",
                     nm, bad, got_idx[bad], got_w[bad], bad, exp_w[bad]);
        end
        check64({nm, "_done_once"}, 64'(n_done), 64'd1);
        check64({nm, "_busy_end"}, {62'h0, busy_end_bad, busy}, 64'h0);
        check64({nm, "_no_err"}, 64'(n_err), 64'd0);
        if (stall) begin
            check64({nm, "_hold"}, 64'(n_hold_bad), 64'd0);
        end else begin
            check64({nm, "_bubbles"}, 64'(n_bubble), 64'd0);
            check64({nm, "_latency"}, 64'(first_valid), 64'(first_xfer + 1));
        end
    endtask

    initial begin
        rst_ext  = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        in_valid = 1'b0;
        in_word  = 64'h0;
        w_ready  = 1'b0;

        vecs[0] = '{2'd0, 64'h61626380, 64'h18, 1'b0, 64'hC2C4C700, 64'h0};
        vecs[1] = '{2'd1, 64'h61626380, 64'h18, 1'b0, 64'h61626380, 64'h000F0000};
        vecs[2] = '{2'd2, 64'h6162638000000000, 64'h18, 1'b0,
                    64'h6162638000000000, 64'h00030000000000C0};
        vecs[3] = '{2'd1, 64'hDEADBEEF61626380, 64'hFFFF000000000018, 1'b1,
                    64'h61626380, 64'h000F0000};
        vecs[4] = '{2'd0, 64'h61626380, 64'h18, 1'b1, 64'hC2C4C700, 64'h0};
        vecs[5] = '{2'd2, 64'h6162638000000000, 64'h18, 1'b1,
                    64'h6162638000000000, 64'h00030000000000C0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check64("reset_w_word", w_word, 64'h0);
        check64("reset_ctrl", {52'h0, w_valid, w_idx, in_ready, busy, done, err}, 64'h0);
        @(posedge clk);
        #1;
        rst_ext = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_blk(vecs[v].w0, vecs[v].w15);
            build_model(vecs[v].m);
            run_block(vecs[v].m, vecs[v].stall, 1'b0, -1, -1);
            check_block($sformatf("v%0d", v), vecs[v].m, vecs[v].stall, vecs[v].e16, vecs[v].e17);
        end

        // Illegal mode: err pulses once, block never starts.
        start = 1'b1;
        mode  = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check64("illegal_err", {62'h0, err, busy}, 64'h2);
        @(posedge clk);
        @(negedge clk);
        check64("illegal_err_clear", {62'h0, err, busy}, 64'h0);
        @(posedge clk);
        #1;

        // Start raised while emitting index 40 of an SHA-1 block is ignored.
        load_blk(64'h61626380, 64'h18);
        build_model(2'd0);
        run_block(2'd0, 1'b0, 1'b0, 40, -1);
        check_block("poke", 2'd0, 1'b0, 64'hC2C4C700, 64'h0);

        // Reset mid-block, then an SHA-256 block started right after reset.
        run_block(2'd0, 1'b0, 1'b0, -1, 30);
        build_model(2'd1);
        run_block(2'd1, 1'b0, 1'b1, -1, -1);
        check_block("post_rst", 2'd1, 1'b0, 64'h61626380, 64'h000F0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
